// File: rtl/ticket_controller.sv
// ticket_controller: price select, payment, dispense and change sequencing.
// Optional PAY inactivity timeout is enabled by defining TICKET_TIMEOUT_EN.
module ticket_controller #(
    parameter int MAX_INSERT         = 99,
    parameter int ALARM_CYCLES       = 2000,
    parameter int CHANGE_HOLD_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] price_sel,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       confirm,
    input  logic       cancel,
    output logic [7:0] display_val,
    output logic [7:0] total_sales,
    output logic [1:0] display_mode,
    output logic       alarm,
    output logic       ticket_out,
    output logic       coin_reject
);
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    localparam int HW = $clog2(CHANGE_HOLD_CYCLES + 1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES);
    localparam logic [AW-1:0] ALARM_ONE  = AW'(1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(CHANGE_HOLD_CYCLES - 1);
    localparam logic [8:0]    MAX_SUM    = 9'(MAX_INSERT);
    localparam logic [8:0]    SALES_CAP  = 9'd99;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAY    = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    inserted;
    logic [7:0]    price_q;
    logic [7:0]    change;
    logic [AW-1:0] alarm_cnt;
    logic [HW-1:0] hold_cnt;

    logic [7:0] coin_sum;
    logic [7:0] cur_price;
    logic [7:0] change_val;
    logic [8:0] pay_sum;
    logic [8:0] sales_sum;
    logic       coin_any;
    logic       refund;
    logic       buy_ok;
    logic       alarm_trig;
    logic       timeout_hit;

    // Price lookup from the selector level.
    always_comb begin
        cur_price = 8'd5;
        unique case (price_sel)
            2'd0: cur_price = 8'd5;
            2'd1: cur_price = 8'd10;
            2'd2: cur_price = 8'd15;
            2'd3: cur_price = 8'd20;
        endcase
    end

    assign coin_sum = (coin_1  ? 8'd1  : 8'd0)
                    + (coin_5  ? 8'd5  : 8'd0)
                    + (coin_10 ? 8'd10 : 8'd0);
    assign coin_any   = coin_1 | coin_5 | coin_10;
    assign pay_sum    = {1'b0, inserted} + {1'b0, coin_sum};
    assign sales_sum  = {1'b0, total_sales} + {1'b0, price_q};
    assign change_val = inserted - price_q;
    assign refund     = cancel | timeout_hit;
    assign buy_ok     = confirm & (inserted >= price_q);

    // Short-payment confirm or an overflowing coin in PAY sounds the alarm.
    assign alarm_trig = (state == PAY) & ~refund &
                        ((confirm & ~buy_ok) |
                         (~confirm & coin_any & (pay_sum > MAX_SUM)));

`ifdef TICKET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == PAY) & ~coin_any & ~confirm &
                         (idle_cnt == TO_LAST);

    // PAY inactivity counter; held at zero outside PAY and on activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (state != PAY || coin_any || confirm)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Alarm hold counter, independent of the sale state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_cnt <= '0;
            alarm     <= 1'b0;
        end else if (alarm_trig) begin
            alarm_cnt <= ALARM_LOAD;
            alarm     <= 1'b1;
        end else if (alarm_cnt != '0) begin
            alarm_cnt <= alarm_cnt - 1'b1;
            alarm     <= (alarm_cnt != ALARM_ONE);
        end else begin
            alarm     <= 1'b0;
        end
    end

    // Sale FSM with registered display and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            inserted     <= '0;
            price_q      <= '0;
            change       <= '0;
            hold_cnt     <= '0;
            total_sales  <= '0;
            display_val  <= '0;
            display_mode <= 2'd0;
            ticket_out   <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            ticket_out  <= 1'b0;
            coin_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    display_mode <= 2'd0;
                    display_val  <= cur_price;
                    if (coin_any) begin
                        state        <= PAY;
                        price_q      <= cur_price;
                        inserted     <= coin_sum;
                        display_mode <= 2'd1;
                        display_val  <= coin_sum;
                    end
                end
                PAY: begin
                    display_mode <= 2'd1;
                    display_val  <= inserted;
                    if (refund) begin
                        coin_reject  <= coin_any;
                        change       <= inserted;
                        hold_cnt     <= '0;
                        state        <= CHANGE;
                        display_mode <= 2'd2;
                        display_val  <= inserted;
                    end else if (confirm) begin
                        coin_reject <= coin_any;
                        if (buy_ok) begin
                            ticket_out   <= 1'b1;
                            change       <= change_val;
                            total_sales  <= (sales_sum > SALES_CAP) ?
                                            SALES_CAP[7:0] : sales_sum[7:0];
                            hold_cnt     <= '0;
                            state        <= CHANGE;
                            display_mode <= 2'd2;
                            display_val  <= change_val;
                        end
                    end else if (coin_any) begin
                        if (pay_sum > MAX_SUM) begin
                            coin_reject <= 1'b1;
                        end else begin
                            inserted    <= pay_sum[7:0];
                            display_val <= pay_sum[7:0];
                        end
                    end
                end
                CHANGE: begin
                    display_mode <= 2'd2;
                    display_val  <= change;
                    coin_reject  <= coin_any;
                    if (hold_cnt == HOLD_LAST) begin
                        state        <= IDLE;
                        inserted     <= '0;
                        change       <= '0;
                        hold_cnt     <= '0;
                        display_mode <= 2'd0;
                        display_val  <= cur_price;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_controller.sv
// tb_ticket_controller: directed vectors for ticket_controller.
// Expected values are hand-computed from the sale rules.
module tb_ticket_controller;
    localparam int HOLD  = 3000;
    localparam int ALARM = 2000;
    localparam int TOUT  = 10000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] price_sel;
    logic       coin_1, coin_5, coin_10, confirm, cancel;
    logic [7:0] display_val;
    logic [7:0] total_sales;
    logic [1:0] display_mode;
    logic       alarm, ticket_out, coin_reject;

    int n_chk = 0;
    int n_err = 0;

    ticket_controller dut (
        .clk         (clk),
        .rst         (rst),
        .price_sel   (price_sel),
        .coin_1      (coin_1),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .confirm     (confirm),
        .cancel      (cancel),
        .display_val (display_val),
        .total_sales (total_sales),
        .display_mode(display_mode),
        .alarm       (alarm),
        .ticket_out  (ticket_out),
        .coin_reject (coin_reject)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v = {coin_1, coin_5, coin_10, confirm, cancel}, one-cycle pulse
    task automatic drive(input logic [4:0] v);
        {coin_1, coin_5, coin_10, confirm, cancel} = v;
        tick();
        {coin_1, coin_5, coin_10, confirm, cancel} = 5'b0;
    endtask

    // Called right after the edge that entered CHANGE.
    task automatic hold_change(input string tag, input logic [7:0] idle_val);
        int cnt;
        cnt = 1;
        tick();
        check({tag, "_tkt_low"}, ticket_out, 0);
        if (display_mode == 2'd2) cnt++;
        while (display_mode == 2'd2 && cnt < HOLD + 100) begin
            tick();
            if (display_mode == 2'd2) cnt++;
        end
        check({tag, "_hold_len"}, cnt, HOLD);
        check({tag, "_idle_mode"}, display_mode, 0);
        check({tag, "_idle_val"}, display_val, idle_val);
    endtask

    task automatic sale20(input logic [7:0] exp_total);
        drive(5'b00100);
        drive(5'b00100);
        drive(5'b00010);
        check("sat_tkt", ticket_out, 1);
        check("sat_total", total_sales, exp_total);
        hold_change("sat", 8'd20);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        price_sel = 2'd1;
        {coin_1, coin_5, coin_10, confirm, cancel} = 5'b0;
        #3;
        check("rst_val", display_val, 0);
        check("rst_total", total_sales, 0);
        check("rst_mode", display_mode, 0);
        check("rst_pulses", {alarm, ticket_out, coin_reject}, 0);
        #7 rst = 1'b0;
        tick();
        check("idle_price", display_val, 10);

        // Normal sale
        drive(5'b00100);
        check("ns_mode", display_mode, 1);
        check("ns_val10", display_val, 10);
        drive(5'b01000);
        check("ns_val15", display_val, 15);
        drive(5'b00010);
        check("ns_tkt", ticket_out, 1);
        check("ns_mode2", display_mode, 2);
        check("ns_change", display_val, 5);
        check("ns_total", total_sales, 10);
        hold_change("ns", 8'd10);

        // Insufficient funds
        price_sel = 2'd3;
        tick();
        check("if_price", display_val, 20);
        drive(5'b00100);
        drive(5'b00010);
        check("if_mode", display_mode, 1);
        check("if_val", display_val, 10);
        check("if_tkt", ticket_out, 0);
        check("if_alarm", alarm, 1);
        cnt = 1;
        while (alarm && cnt < ALARM + 100) begin
            tick();
            if (alarm) cnt++;
        end
        check("if_alarm_len", cnt, ALARM);
        check("if_still_pay", display_mode, 1);
        drive(5'b00001);
        check("if_cancel_val", display_val, 10);
        check("if_total", total_sales, 10);
        hold_change("if", 8'd20);

        // Overflow
        price_sel = 2'd0;
        for (int i = 0; i < 9; i++) drive(5'b00100);
        drive(5'b01000);
        check("ov_95", display_val, 95);
        drive(5'b00100);
        check("ov_reject", coin_reject, 1);
        check("ov_alarm", alarm, 1);
        check("ov_kept", display_val, 95);
        for (int i = 0; i < 4; i++) drive(5'b10000);
        check("ov_99", display_val, 99);
        check("ov_99_acc", coin_reject, 0);
        drive(5'b10000);
        check("ov_100_rej", coin_reject, 1);
        drive(5'b00010);
        check("ov_change", display_val, 94);
        check("ov_total", total_sales, 15);
        hold_change("ov", 8'd5);

        // Simultaneous coins, then confirm with a coin
        price_sel = 2'd1;
        drive(5'b01100);
        check("sim_15", display_val, 15);
        drive(5'b10010);
        check("sim_tkt", ticket_out, 1);
        check("sim_rej", coin_reject, 1);
        check("sim_change", display_val, 5);
        check("sim_total", total_sales, 25);
        hold_change("sim", 8'd10);

        // Exact payment: zero change
        drive(5'b00100);
        drive(5'b00010);
        check("z_mode", display_mode, 2);
        check("z_change", display_val, 0);
        check("z_total", total_sales, 35);
        hold_change("z", 8'd10);

        // Cancel refund, coin during CHANGE
        drive(5'b00100);
        drive(5'b10000);
        drive(5'b10000);
        drive(5'b00001);
        check("cn_mode", display_mode, 2);
        check("cn_val", display_val, 12);
        check("cn_total", total_sales, 35);
        drive(5'b01000);
        check("cn_rej", coin_reject, 1);
        check("cn_noalarm", alarm, 0);
        check("cn_val2", display_val, 12);
        cnt = 2;
        while (display_mode == 2'd2 && cnt < HOLD + 100) begin
            tick();
            if (display_mode == 2'd2) cnt++;
        end
        check("cn_hold_len", cnt, HOLD);

        // Saturation of total_sales
        price_sel = 2'd3;
        sale20(8'd55);
        sale20(8'd75);
        sale20(8'd95);
        sale20(8'd99);
        sale20(8'd99);

        // Asynchronous reset mid-PAY
        drive(5'b01000);
        check("rp_pay", display_mode, 1);
        #2 rst = 1'b1;
        #1;
        check("rp_val", display_val, 0);
        check("rp_total", total_sales, 0);
        check("rp_mode", display_mode, 0);
        check("rp_pulses", {alarm, ticket_out, coin_reject}, 0);
        #2 rst = 1'b0;
        tick();
        check("rp_price", display_val, 20);
        check("rp_idle", display_mode, 0);

`ifdef TICKET_TIMEOUT_EN
        drive(5'b01000);
        cnt = 0;
        while (display_mode == 2'd1 && cnt < TOUT + 100) begin
            tick();
            cnt++;
        end
        check("to_len", cnt, TOUT);
        check("to_mode", display_mode, 2);
        check("to_val", display_val, 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ticket_controller.md
# ticket_controller

Transaction controller for the ticket machine. It takes price selection, debounced coin pulses and confirm/cancel pulses, and runs the sale: accumulate payment, check it against the price, dispense, and compute change. It sits directly upstream of the 7-segment display driver and supplies its `display_val`, `total_sales`, `display_mode` and `alarm` inputs. All values are binary, 0–99.

## Interface
- `MAX_INSERT`, 99: ceiling on the accumulated payment.
- `ALARM_CYCLES`, 2000: alarm hold length, in cycles.
- `CHANGE_HOLD_CYCLES`, 3000: how long the CHANGE screen is shown, in cycles.
- `TIMEOUT_CYCLES`, 10000: inactivity limit in PAY; used only under `TICKET_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `price_sel` in 2: level input; 0→5, 1→10, 2→15, 3→20.
- `coin_1`, `coin_5`, `coin_10` in 1 each: single-cycle coin pulses of value 1, 5 and 10.
- `confirm` in 1: single-cycle pulse; buy.
- `cancel` in 1: single-cycle pulse; refund.
- `display_val` out 8: price, inserted amount or change, depending on mode.
- `total_sales` out 8: accumulated revenue, saturating at 99.
- `display_mode` out 2: 0 = price, 1 = inserted, 2 = change; 3 is never driven.
- `alarm` out 1: high while the alarm counter is nonzero.
- `ticket_out` out 1: one-cycle dispense pulse.
- `coin_reject` out 1: one-cycle pulse; a coin arrived but was not credited.

## Operation
- States and transitions:
  - IDLE to PAY.
  - PAY to CHANGE.
  - CHANGE to IDLE.
- Registers:
  - `inserted[7:0]`
  - `price_q[7:0]`
  - `change[7:0]`
  - `total_sales`
  - alarm counter
  - hold counter
- `coin_sum` = 1·`coin_1` + 5·`coin_5` + 10·`coin_10`. Simultaneous coins add.
- IDLE:
  - `display_mode`=0; `display_val`=price(`price_sel`), tracking `price_sel` continuously.
  - `coin_sum`≠0: `price_q`←price(`price_sel`), `inserted`←`coin_sum`, go to PAY.
  - `confirm` and `cancel` are ignored.
- PAY (`display_mode`=1, `display_val`=`inserted`; `price_sel` is ignored). Priority is `cancel` > `confirm` > coins:
  - `cancel`: `change`←`inserted`, go to CHANGE. No sale, no ticket.
  - `confirm` with `inserted` ≥ `price_q`:
    - `ticket_out`=1.
    - `change`←`inserted`−`price_q`.
    - `total_sales`←min(99, `total_sales`+`price_q`).
    - Go to CHANGE.
  - `confirm` with `inserted` < `price_q`: load the alarm counter and stay in PAY.
  - A coin in the same cycle as `confirm` or `cancel` is not credited: `coin_reject`=1.
  - Coin with `inserted`+`coin_sum` > `MAX_INSERT`:
    - The whole `coin_sum` is rejected: `coin_reject`=1, alarm loaded, `inserted` unchanged.
    - The sum is computed 9 bits wide.
  - Otherwise a coin adds to `inserted`.
- CHANGE:
  - `display_mode`=2, `display_val`=`change`.
  - Hold counter runs for `CHANGE_HOLD_CYCLES`, then go to IDLE with `inserted`=`change`=0.
  - Coins: `coin_reject`=1, no alarm.
  - `confirm` and `cancel` are ignored.
- Alarm:
  - Counter loads `ALARM_CYCLES` on a trigger; reloads on retrigger; decrements to 0.
  - `alarm` = (counter≠0).
  - The alarm counter is independent of state and keeps counting across transitions.

## Timing
- All outputs are registered.
- An input pulse at edge N is reflected in the outputs after edge N (1-cycle latency).
- `ticket_out` and `coin_reject` are exactly one cycle wide and fire in the same cycle as the corresponding state/data update.
- CHANGE lasts exactly `CHANGE_HOLD_CYCLES` cycles; IDLE is visible on the following cycle.
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE; `display_val`, `total_sales`, `display_mode` = 0.
  - `alarm`, `ticket_out`, `coin_reject` = 0.
  - All internal counters and registers = 0.
  - An in-progress payment is discarded.
  - After the first post-reset edge, `display_val` = the selected price.
- Boundary conditions:
  - `inserted` = `MAX_INSERT` exactly is allowed.
  - `change` = 0 is displayed as 0 and still holds for the full CHANGE duration.
  - `total_sales` stays at 99 once reached.

## Configuration
- `TICKET_TIMEOUT_EN` defined:
  - In PAY, an inactivity counter clears on any coin pulse or `confirm`, and otherwise increments.
  - When it reaches `TIMEOUT_CYCLES`, the block behaves exactly as a `cancel` (refund into CHANGE).
  - The counter is cleared on entry to PAY.
- `TICKET_TIMEOUT_EN` undefined: there is no inactivity counter, and PAY waits indefinitely.

## Test plan
- Normal sale:
  - Stimulus: `price_sel`=1, then `coin_10`, `coin_5`, `confirm`.
  - Required response: `display_val` 10→10→15; `ticket_out` pulse; mode=2 with `display_val`=5; `total_sales`=10; IDLE after `CHANGE_HOLD_CYCLES`.
- Insufficient funds:
  - Stimulus: `price_sel`=3, `coin_10`, `confirm`.
  - Required response: stays in PAY with `display_val`=10; `alarm` high for `ALARM_CYCLES`; no `ticket_out`.
- Overflow:
  - Stimulus: `inserted`=95, then `coin_10`.
  - Required response: `coin_reject` pulse; `alarm` asserted; `inserted` stays 95.
  - Follow-up: `coin_1` ×4 → `inserted`=99 accepted.
- Simultaneous events:
  - Stimulus: `coin_5`+`coin_10` in the same cycle in IDLE.
  - Required response: `inserted`=15.
  - Follow-up: `confirm`+`coin_1` in the same cycle → sale proceeds and `coin_reject`=1.
- Cancel and reset:
  - Stimulus: pay 12, `cancel`.
  - Required response: CHANGE with `display_val`=12; `total_sales` unchanged.
  - Follow-up: assert `rst` mid-PAY → all outputs 0 asynchronously.
- Timeout (with `TICKET_TIMEOUT_EN`):
  - Stimulus: `coin_5`, then no activity for `TIMEOUT_CYCLES`.
  - Required response: CHANGE with `display_val`=5.
